// File: rtl/intel_issp_reset_probe_pkg.sv
// Shared types and helpers for the ISSP reset probe: the per-domain phase
// encoding seen on the probe port and a saturating increment.
package intel_issp_reset_probe_pkg;

  localparam int MAX_RESETS = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    IN_RESET   = 2'd1,
    WAIT_READY = 2'd2,
    READY      = 2'd3
  } phase_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/intel_issp_reset_probe_chan.sv
// One monitored reset domain: phase FSM, saturating event counter,
// release-to-ready latency measurement and sticky timeout flag.
module intel_issp_reset_probe_chan
  import intel_issp_reset_probe_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int LAT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             reset_mon_i,
  input  logic             ready_i,
  input  logic             clear_i,
  output logic [1:0]       phase_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] count_o,
  output logic [LAT_W-1:0] latency_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LAT_W-1:0] LAT_MAX = '1;

  phase_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LAT_W-1:0] work_q, work_d, work_inc;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             to_q, to_d;
  logic             evt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      lat_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      lat_q   <= lat_d;
      to_q    <= to_d;
    end
  end

  // Clear is applied first so that a same-cycle capture, timeout or count
  // event overrides it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    lat_d    = lat_q;
    to_d     = to_q;
    evt      = 1'b0;
    work_inc = LAT_W'(sat_inc(32'(work_q), 32'(LAT_MAX)));
    if (clear_i) begin
      cnt_d = '0;
      lat_d = '0;
      to_d  = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (reset_mon_i) begin
          state_d = IN_RESET;
          evt     = 1'b1;
        end else if (ready_i) begin
          state_d = READY;
        end
      end
      IN_RESET: begin
        // The release cycle itself counts as one cycle of waiting unless
        // ready is already present, which must read back as zero.
        if (!reset_mon_i) begin
          state_d = WAIT_READY;
          work_d  = ready_i ? '0 : LAT_W'(1);
        end
      end
      WAIT_READY: begin
        if (reset_mon_i) begin
          state_d = IN_RESET;
          evt     = 1'b1;
        end else if (ready_i) begin
          state_d = READY;
          lat_d   = work_q;
        end else if (work_inc == LAT_MAX) begin
          state_d = READY;
          lat_d   = LAT_MAX;
          to_d    = 1'b1;
        end else begin
          work_d = work_inc;
        end
      end
      READY: begin
        if (reset_mon_i) begin
          state_d = IN_RESET;
          evt     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (evt) begin
      cnt_d = clear_i ? CNT_W'(1) : CNT_W'(sat_inc(32'(cnt_q), 32'(CNT_MAX)));
    end
  end

  assign phase_o   = state_q;
  assign timeout_o = to_q;
  assign count_o   = cnt_q;
  assign latency_o = lat_q;

endmodule

// File: rtl/intel_issp_reset_probe.sv
// ISSP reset return path: per-domain status channels, clear edge detect and
// registered readout mux. Define INTEL_ISSP_RESET_PROBE_SYNC_EN for 2-flop input synchronisers.
module intel_issp_reset_probe
  import intel_issp_reset_probe_pkg::*;
#(
  parameter  int NUM_RESETS = 4,
  parameter  int CNT_W      = 8,
  parameter  int LAT_W      = 16,
  localparam int SEL_W      = (NUM_RESETS > 1) ? $clog2(NUM_RESETS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_RESETS-1:0]   reset_mon_in,
  input  logic [NUM_RESETS-1:0]   ready_mon_in,
  input  logic                    issp_clear_in,
  input  logic [SEL_W-1:0]        issp_sel_in,
  output logic [2*NUM_RESETS-1:0] probe_phase_out,
  output logic [NUM_RESETS-1:0]   probe_timeout_out,
  output logic [CNT_W-1:0]        probe_count_out,
  output logic [LAT_W-1:0]        probe_latency_out
);

  if (NUM_RESETS < 1 || NUM_RESETS > MAX_RESETS) begin : g_bad_num_resets
    $error("NUM_RESETS out of range");
  end

  logic [NUM_RESETS-1:0] rm_w, rdy_w;
  logic                  clr_w, clr_prev_q, clr_pulse;
  logic [SEL_W-1:0]      sel_w;

`ifdef INTEL_ISSP_RESET_PROBE_SYNC_EN
  logic [NUM_RESETS-1:0] rm_s1_q, rm_s2_q, rdy_s1_q, rdy_s2_q;
  logic                  clr_s1_q, clr_s2_q;
  logic [SEL_W-1:0]      sel_s1_q, sel_s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rm_s1_q  <= '0;
      rm_s2_q  <= '0;
      rdy_s1_q <= '0;
      rdy_s2_q <= '0;
      clr_s1_q <= 1'b0;
      clr_s2_q <= 1'b0;
      sel_s1_q <= '0;
      sel_s2_q <= '0;
    end else begin
      rm_s1_q  <= reset_mon_in;
      rm_s2_q  <= rm_s1_q;
      rdy_s1_q <= ready_mon_in;
      rdy_s2_q <= rdy_s1_q;
      clr_s1_q <= issp_clear_in;
      clr_s2_q <= clr_s1_q;
      sel_s1_q <= issp_sel_in;
      sel_s2_q <= sel_s1_q;
    end
  end

  assign rm_w  = rm_s2_q;
  assign rdy_w = rdy_s2_q;
  assign clr_w = clr_s2_q;
  assign sel_w = sel_s2_q;
`else
  assign rm_w  = reset_mon_in;
  assign rdy_w = ready_mon_in;
  assign clr_w = issp_clear_in;
  assign sel_w = issp_sel_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) clr_prev_q <= 1'b0;
    else     clr_prev_q <= clr_w;
  end

  assign clr_pulse = clr_w & ~clr_prev_q;

  logic [CNT_W-1:0] cnt_w [NUM_RESETS];
  logic [LAT_W-1:0] lat_w [NUM_RESETS];

  for (genvar g = 0; g < NUM_RESETS; g++) begin : g_chan
    intel_issp_reset_probe_chan #(
      .CNT_W(CNT_W),
      .LAT_W(LAT_W)
    ) u_chan (
      .clk_i      (clk),
      .rst_i      (rst),
      .reset_mon_i(rm_w[g]),
      .ready_i    (rdy_w[g]),
      .clear_i    (clr_pulse),
      .phase_o    (probe_phase_out[2*g +: 2]),
      .timeout_o  (probe_timeout_out[g]),
      .count_o    (cnt_w[g]),
      .latency_o  (lat_w[g])
    );
  end

  // Selects that match no domain fall through to zero.
  logic [CNT_W-1:0] cnt_sel;
  logic [LAT_W-1:0] lat_sel;
  logic [CNT_W-1:0] count_q;
  logic [LAT_W-1:0] latency_q;

  always_comb begin
    cnt_sel = '0;
    lat_sel = '0;
    for (int i = 0; i < NUM_RESETS; i++) begin
      if (sel_w == SEL_W'(i)) begin
        cnt_sel = cnt_w[i];
        lat_sel = lat_w[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      latency_q <= '0;
    end else begin
      count_q   <= cnt_sel;
      latency_q <= lat_sel;
    end
  end

  assign probe_count_out   = count_q;
  assign probe_latency_out = latency_q;

endmodule

// File: tb/tb_intel_issp_reset_probe.sv
// Bench for intel_issp_reset_probe: directed scenarios with literal pins,
// then randomized traffic compared every cycle against a timestamp-based model.
module tb_intel_issp_reset_probe;

  localparam int N       = 5;
  localparam int CNT_W   = 8;
  localparam int LAT_W   = 4;
  localparam int SEL_W   = 3;
  localparam int CNT_MAX = 255;
  localparam int LAT_MAX = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     rm;
  logic [N-1:0]     rdy;
  logic             clr;
  logic [SEL_W-1:0] sel;
  logic [2*N-1:0]   probe_phase_out;
  logic [N-1:0]     probe_timeout_out;
  logic [CNT_W-1:0] probe_count_out;
  logic [LAT_W-1:0] probe_latency_out;

  intel_issp_reset_probe #(
    .NUM_RESETS(N),
    .CNT_W     (CNT_W),
    .LAT_W     (LAT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .reset_mon_in     (rm),
    .ready_mon_in     (rdy),
    .issp_clear_in    (clr),
    .issp_sel_in      (sel),
    .probe_phase_out  (probe_phase_out),
    .probe_timeout_out(probe_timeout_out),
    .probe_count_out  (probe_count_out),
    .probe_latency_out(probe_latency_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // behavioural model: phases per the domain rules, latency from timestamps
  int  m_ph      [N];
  int  m_cnt     [N];
  int  m_lat     [N];
  int  m_rel     [N];
  int  m_rel_rdy [N];
  bit  m_to      [N];
  bit  m_clr_prev;
  bit  m_valid = 1'b0;
  int  cyc = 0;
  logic [CNT_W+LAT_W-1:0] exp_q[$];

  task automatic model_step();
    bit clr_edge;
    bit evt;
    int elapsed;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_ph[i] = 0; m_cnt[i] = 0; m_lat[i] = 0; m_to[i] = 1'b0;
        m_rel[i] = 0; m_rel_rdy[i] = 0;
      end
      m_clr_prev = 1'b0;
      exp_q.delete();
      exp_q.push_back('0);
      m_valid = 1'b1;
      cyc++;
      return;
    end
    if (!m_valid) return;
    if (int'(sel) < N) exp_q.push_back({CNT_W'(m_cnt[sel]), LAT_W'(m_lat[sel])});
    else exp_q.push_back('0);
    clr_edge   = clr && !m_clr_prev;
    m_clr_prev = clr;
    for (int i = 0; i < N; i++) begin
      evt = 1'b0;
      if (clr_edge) begin
        m_cnt[i] = 0; m_lat[i] = 0; m_to[i] = 1'b0;
      end
      elapsed = cyc - m_rel[i] - m_rel_rdy[i];
      case (m_ph[i])
        0: if (rm[i]) begin m_ph[i] = 1; evt = 1'b1; end
           else if (rdy[i]) m_ph[i] = 3;
        1: if (!rm[i]) begin m_ph[i] = 2; m_rel[i] = cyc; m_rel_rdy[i] = int'(rdy[i]); end
        2: if (rm[i]) begin m_ph[i] = 1; evt = 1'b1; end
           else if (rdy[i]) begin m_ph[i] = 3; m_lat[i] = elapsed; end
           else if (elapsed + 1 >= LAT_MAX) begin m_ph[i] = 3; m_lat[i] = LAT_MAX; m_to[i] = 1'b1; end
        default: if (rm[i]) begin m_ph[i] = 1; evt = 1'b1; end
      endcase
      if (evt) m_cnt[i] = clr_edge ? 1 : ((m_cnt[i] < CNT_MAX) ? m_cnt[i] + 1 : CNT_MAX);
    end
    cyc++;
  endtask

  // scoreboard: compare on the falling edge, then advance the model
  logic [2*N-1:0]         e_ph;
  logic [N-1:0]           e_to;
  logic [CNT_W+LAT_W-1:0] e_rd;

  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < N; i++) begin
        e_ph[2*i +: 2] = 2'(m_ph[i]);
        e_to[i]        = m_to[i];
      end
      check("phase", 32'(probe_phase_out), 32'(e_ph));
      check("timeout", 32'(probe_timeout_out), 32'(e_to));
      if (exp_q.size() > 0) begin
        e_rd = exp_q.pop_front();
        check("count", 32'(probe_count_out), 32'(e_rd[CNT_W+LAT_W-1:LAT_W]));
        check("latency", 32'(probe_latency_out), 32'(e_rd[LAT_W-1:0]));
      end
    end
    model_step();
  end

  // driver
  int since [N];
  int dly   [N];

  initial begin
    rst = 1'b1; rm = '0; rdy = '0; clr = 1'b0; sel = '0;
    repeat (3) tick();
    check("rst_phase", 32'(probe_phase_out), 32'd0);
    check("rst_timeout", 32'(probe_timeout_out), 32'd0);
    check("rst_count", 32'(probe_count_out), 32'd0);
    check("rst_latency", 32'(probe_latency_out), 32'd0);
    rst = 1'b0;

    // domain 0: 5-cycle reset, ready 10 cycles after release
    rm[0] = 1'b1; repeat (5) tick();
    rm[0] = 1'b0; repeat (10) tick();
    rdy[0] = 1'b1; repeat (3) tick();
    check("d0_count", 32'(probe_count_out), 32'd1);
    check("d0_latency", 32'(probe_latency_out), 32'd10);
    check("d0_phase", 32'(probe_phase_out[1:0]), 32'd3);
    check("d0_timeout", 32'(probe_timeout_out[0]), 32'd0);

    // domain 2: 300 pulses saturate the event counter
    sel = 3'd2;
    for (int k = 0; k < 300; k++) begin
      rm[2] = 1'b1; tick();
      rm[2] = 1'b0; tick();
    end
    rdy[2] = 1'b1; repeat (2) tick();
    check("d2_count_sat", 32'(probe_count_out), 32'd255);
    sel = 3'd1; tick();
    check("d1_count_zero", 32'(probe_count_out), 32'd0);
    sel = 3'd3; tick();
    check("d3_count_zero", 32'(probe_count_out), 32'd0);

    // domain 1: ready never rises -> timeout
    sel = 3'd1;
    rm[1] = 1'b1; repeat (2) tick();
    rm[1] = 1'b0; repeat (14) tick();
    check("d1_pre_timeout", 32'(probe_timeout_out[1]), 32'd0);
    check("d1_pre_phase", 32'(probe_phase_out[3:2]), 32'd2);
    tick();
    check("d1_timeout", 32'(probe_timeout_out[1]), 32'd1);
    check("d1_phase", 32'(probe_phase_out[3:2]), 32'd3);
    tick();
    check("d1_latency", 32'(probe_latency_out), 32'd15);

    // domain 3: completed latency 3, then reset reasserts mid-wait
    sel = 3'd3;
    rm[3] = 1'b1; tick();
    rm[3] = 1'b0; repeat (3) tick();
    rdy[3] = 1'b1; repeat (2) tick();
    check("d3_first_latency", 32'(probe_latency_out), 32'd3);
    rdy[3] = 1'b0; rm[3] = 1'b1; tick();
    rm[3] = 1'b0; repeat (4) tick();
    rm[3] = 1'b1; repeat (2) tick();
    check("d3_count", 32'(probe_count_out), 32'd3);
    check("d3_latency_kept", 32'(probe_latency_out), 32'd3);
    check("d3_phase", 32'(probe_phase_out[7:6]), 32'd1);

    // clear edge coincident with a domain 0 reset edge
    sel = 3'd0; clr = 1'b1; rm[0] = 1'b1; rdy[0] = 1'b0; repeat (2) tick();
    check("clr_count0", 32'(probe_count_out), 32'd1);
    check("clr_latency0", 32'(probe_latency_out), 32'd0);
    check("clr_timeout", 32'(probe_timeout_out), 32'd0);
    check("clr_phases", 32'(probe_phase_out), 32'b00_01_11_11_01);
    sel = 3'd2; tick();
    check("clr_count2", 32'(probe_count_out), 32'd0);
    sel = 3'd6; tick();
    check("sel_out_of_range", 32'(probe_count_out), 32'd0);
    clr = 1'b0;

    // randomized traffic
    for (int i = 0; i < N; i++) begin
      since[i] = 0;
      dly[i]   = $urandom_range(0, 18);
    end
    for (int it = 0; it < 3000; it++) begin
      if (it == 1500) rst = 1'b1;
      else if (it == 1502) rst = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (rm[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            rm[i] = 1'b0; since[i] = 0; dly[i] = $urandom_range(0, 18);
          end
        end else begin
          since[i]++;
          if ($urandom_range(0, 24) == 0) rm[i] = 1'b1;
        end
        rdy[i] = !rm[i] && (since[i] >= dly[i]);
      end
      if ($urandom_range(0, 15) == 0) clr = ~clr;
      sel = SEL_W'($urandom_range(0, 7));
      tick();
    end
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
